// File: rtl/lpif_flit_pkg.sv
// Shared definitions for the upstream LPIF flit assembler.
//   STATE_ACTIVE_DEF : default ustrm_state encoding in which beats are assembled
//   flit_t           : completed-flit record (data, protid, err) at the default
//                      flit size; the assembler builds the same shape for its BEATS
//   crc4_fold        : 4-bit XOR fold of one 64-bit beat
//   sat_inc          : saturating 8-bit increment for event counters
package lpif_flit_pkg;

    localparam logic [3:0] STATE_ACTIVE_DEF = 4'h1;
    localparam int         FLIT_BEATS_DEF   = 4;

    typedef struct packed {
        logic [64*FLIT_BEATS_DEF-1:0] data;
        logic [1:0]                   protid;
        logic                         err;
    } flit_t;

    // Bit i of the result is the XOR of every data bit whose index mod 4 is i.
    // A beat is 64 bits wide (a multiple of 4), so folding a whole flit is the
    // XOR of the per-beat folds, which lets the assembler accumulate per beat.
    function automatic logic [3:0] crc4_fold(input logic [63:0] d);
        logic [3:0] acc;
        acc = 4'h0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ d[4*i +: 4];
        end
        return acc;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/lpif_flit_fifo.sv
// Synchronous first-word-fall-through FIFO of completed flits.
//   clk, srst        : clock and synchronous active-high reset
//   i_push, i_data   : write request and entry; accepted when not full, or when
//                      a pop happens in the same cycle
//   o_full           : no free entry
//   i_pop            : remove the head (ignored when empty)
//   o_data, o_empty  : head entry (all zero while empty) and empty flag
module lpif_flit_fifo
    import lpif_flit_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = flit_t
) (
    input  logic clk,
    input  logic srst,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    input  logic i_pop,
    output T     o_data,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer bit: equal pointers mean empty, differing only in the
    // top bit means full.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // Mask the head while empty so stale entries never reach the outputs.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/lpif_ustrm_flit_asm.sv
// Upstream flit assembler: packs BEATS accepted 64-bit ustrm beats into a flit,
// checks protid consistency and the end-of-flit CRC nibble, and queues finished
// flits in a small valid/ready FIFO.
//   clk_wr, rst_wr         : clock, synchronous active-high reset
//   rx_online, ustrm_*     : beat stream from the LPIF master (no backpressure)
//   flit_data/protid/      : FIFO head; flit_crc_err flags a CRC or protid
//   crc_err/valid, ready     mismatch inside that flit
//   lp_state               : last ustrm_state seen with ustrm_valid
//   *_cnt                  : saturating abort/framing/CRC/overflow counters
module lpif_ustrm_flit_asm
    import lpif_flit_pkg::*;
#(
    parameter int         BEATS        = 4,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [3:0] STATE_ACTIVE = STATE_ACTIVE_DEF
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 rx_online,
    input  logic [3:0]           ustrm_state,
    input  logic [1:0]           ustrm_protid,
    input  logic [63:0]          ustrm_data,
    input  logic                 ustrm_dvalid,
    input  logic [3:0]           ustrm_crc,
    input  logic                 ustrm_crc_valid,
    input  logic                 ustrm_valid,
    output logic [64*BEATS-1:0]  flit_data,
    output logic [1:0]           flit_protid,
    output logic                 flit_crc_err,
    output logic                 flit_valid,
    input  logic                 flit_ready,
    output logic [3:0]           lp_state,
    output logic [7:0]           abort_cnt,
    output logic [7:0]           frame_err_cnt,
    output logic [7:0]           crc_err_cnt,
    output logic [7:0]           ovfl_cnt
);

    localparam int            BW        = $clog2(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [64*BEATS-1:0] data;
        logic [1:0]          protid;
        logic                err;
    } asm_flit_t;

    logic [1:0]          r_state;
    logic [BW-1:0]       r_bcnt;
    logic [64*BEATS-1:0] r_asm_data;
    logic [1:0]          r_protid;
    logic                r_err;
    logic [3:0]          r_crc_acc;
    logic [3:0]          r_lp_state;
    logic [7:0]          r_abort_cnt;
    logic [7:0]          r_frame_cnt;
    logic [7:0]          r_crc_cnt;
    logic [7:0]          r_ovfl_cnt;

    logic [1:0]          w_state_next;
    logic [BW-1:0]       w_bcnt_next;
    logic                w_beat;
    logic                w_in_fill;
    logic                w_at_last;
    logic                w_start;
    logic                w_cont;
    logic                w_abort;
    logic                w_frame_err;
    logic [3:0]          w_crc;
    logic                w_crc_bad;
    logic                w_prot_bad;
    logic [BEATS-1:0]    w_lane_we;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_ovfl;
    asm_flit_t           w_flit_in;
    asm_flit_t           w_flit_head;

    assign w_beat    = rx_online & ustrm_valid & ustrm_dvalid & (ustrm_state == STATE_ACTIVE);
    assign w_in_fill = (r_state == ST_FILL);
    assign w_at_last = w_in_fill & (r_bcnt == LAST_BEAT);
    // IDLE and DONE both start a new flit, which is what gives gapless flits.
    assign w_start   = w_beat & ~w_in_fill;
    assign w_cont    = w_beat & w_in_fill;
    assign w_abort   = w_in_fill & (~rx_online | (ustrm_state != STATE_ACTIVE));
    // crc_valid must appear on exactly the last beat of a flit.
    assign w_frame_err = w_beat & (ustrm_crc_valid != w_at_last);
    assign w_crc       = r_crc_acc ^ crc4_fold(ustrm_data);
    assign w_crc_bad   = w_beat & w_at_last & ~w_frame_err & (w_crc != ustrm_crc);
    assign w_prot_bad  = w_cont & (ustrm_protid != r_protid);

    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        case (r_state)
            ST_FILL: begin
                if (w_abort) begin
                    w_state_next = ST_IDLE;
                    w_bcnt_next  = '0;
                end else if (w_beat) begin
                    if (w_frame_err) begin
                        w_state_next = ST_IDLE;
                        w_bcnt_next  = '0;
                    end else if (w_at_last) begin
                        w_state_next = ST_DONE;
                        w_bcnt_next  = '0;
                    end else begin
                        w_bcnt_next  = r_bcnt + 1'b1;
                    end
                end
            end
            default: begin
                if (w_beat & ~w_frame_err) begin
                    w_state_next = ST_FILL;
                    w_bcnt_next  = BW'(1);
                end else begin
                    w_state_next = ST_IDLE;
                    w_bcnt_next  = '0;
                end
            end
        endcase
    end

    // bcnt is 0 in IDLE and DONE, so the lane select also covers the first beat.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            localparam logic [BW-1:0] LANE = BW'(gi);
            assign w_lane_we[gi] = w_beat & (r_bcnt == LANE);
        end
    endgenerate

    // Writing lane 0 during DONE is safe: the push samples the old contents.
    always_ff @(posedge clk_wr) begin
        for (int i = 0; i < BEATS; i++) begin
            if (w_lane_we[i]) r_asm_data[64*i +: 64] <= ustrm_data;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_state     <= ST_IDLE;
            r_bcnt      <= '0;
            r_protid    <= 2'b00;
            r_err       <= 1'b0;
            r_crc_acc   <= 4'h0;
            r_lp_state  <= 4'h0;
            r_abort_cnt <= 8'h00;
            r_frame_cnt <= 8'h00;
            r_crc_cnt   <= 8'h00;
            r_ovfl_cnt  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_bcnt  <= w_bcnt_next;
            if (ustrm_valid) r_lp_state <= ustrm_state;
            if (w_start) begin
                r_protid  <= ustrm_protid;
                r_err     <= 1'b0;
                r_crc_acc <= crc4_fold(ustrm_data);
            end else if (w_cont) begin
                r_crc_acc <= w_crc;
                if (w_prot_bad | w_crc_bad) r_err <= 1'b1;
            end
            if (w_abort)     r_abort_cnt <= sat_inc(r_abort_cnt);
            if (w_frame_err) r_frame_cnt <= sat_inc(r_frame_cnt);
            if (w_crc_bad)   r_crc_cnt   <= sat_inc(r_crc_cnt);
            if (w_ovfl)      r_ovfl_cnt  <= sat_inc(r_ovfl_cnt);
        end
    end

    assign w_push           = (r_state == ST_DONE);
    assign w_pop            = ~w_empty & flit_ready;
    assign w_ovfl           = w_push & w_full & ~w_pop;
    assign w_flit_in.data   = r_asm_data;
    assign w_flit_in.protid = r_protid;
    assign w_flit_in.err    = r_err;

    lpif_flit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (asm_flit_t)
    ) u_fifo (
        .clk     (clk_wr),
        .srst    (rst_wr),
        .i_push  (w_push),
        .i_data  (w_flit_in),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_data  (w_flit_head),
        .o_empty (w_empty)
    );

    assign flit_valid    = ~w_empty;
    assign flit_data     = w_flit_head.data;
    assign flit_protid   = w_flit_head.protid;
    assign flit_crc_err  = w_flit_head.err;
    assign lp_state      = r_lp_state;
    assign abort_cnt     = r_abort_cnt;
    assign frame_err_cnt = r_frame_cnt;
    assign crc_err_cnt   = r_crc_cnt;
    assign ovfl_cnt      = r_ovfl_cnt;

endmodule

// File: tb/tb_lpif_ustrm_flit_asm.sv
module tb_lpif_ustrm_flit_asm;

    localparam int BEATS = 4;
    localparam int DEPTH = 4;

    logic         clk_wr = 1'b0;
    logic         rst_wr;
    logic         rx_online;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [63:0]  ustrm_data;
    logic         ustrm_dvalid;
    logic [3:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;
    logic [255:0] flit_data;
    logic [1:0]   flit_protid;
    logic         flit_crc_err;
    logic         flit_valid;
    logic         flit_ready;
    logic [3:0]   lp_state;
    logic [7:0]   abort_cnt, frame_err_cnt, crc_err_cnt, ovfl_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_ustrm_flit_asm #(.BEATS(BEATS), .FIFO_DEPTH(DEPTH), .STATE_ACTIVE(4'h1)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .rx_online(rx_online),
        .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
        .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
        .ustrm_valid(ustrm_valid), .flit_data(flit_data), .flit_protid(flit_protid),
        .flit_crc_err(flit_crc_err), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .lp_state(lp_state), .abort_cnt(abort_cnt), .frame_err_cnt(frame_err_cnt),
        .crc_err_cnt(crc_err_cnt), .ovfl_cnt(ovfl_cnt)
    );

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Whole-flit fold straight from the definition: bit i collects data bits with index mod 4 == i.
    function automatic logic [3:0] ref_fold(input logic [255:0] d);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 256; i++) r[i % 4] = r[i % 4] ^ d[i];
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [255:0] data;
        logic [1:0]   prot;
        logic         err;
    } mflit_t;

    mflit_t      m_fifo[$];
    mflit_t      m_pend;
    bit          m_pend_v;
    logic [63:0] m_beats[$];
    logic [1:0]  m_prot;
    bit          m_err;
    int          m_abort, m_frame, m_crc, m_ovfl;
    logic [3:0]  m_lp;
    bit          live = 0;

    always @(posedge clk_wr) begin
        bit           acc;
        bit           pop;
        int           idx;
        logic [255:0] all;
        if (rst_wr) begin
            m_fifo.delete(); m_beats.delete(); m_pend_v = 0;
            m_abort = 0; m_frame = 0; m_crc = 0; m_ovfl = 0; m_lp = 4'h0; m_err = 0;
            live = 1;
        end else begin
            pop = (m_fifo.size() > 0) && flit_ready;
            if (pop) void'(m_fifo.pop_front());
            if (m_pend_v) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend);
                else m_ovfl++;
                m_pend_v = 0;
            end
            if (ustrm_valid) m_lp = ustrm_state;
            acc = rx_online && ustrm_valid && ustrm_dvalid && (ustrm_state == 4'h1);
            if (m_beats.size() > 0 && (!rx_online || ustrm_state != 4'h1)) begin
                m_abort++;
                m_beats.delete();
            end else if (acc) begin
                idx = m_beats.size();
                if (ustrm_crc_valid != (idx == BEATS - 1)) begin
                    m_frame++;
                    m_beats.delete();
                end else begin
                    if (idx == 0) begin
                        m_prot = ustrm_protid;
                        m_err  = 0;
                    end else if (ustrm_protid != m_prot) begin
                        m_err = 1;
                    end
                    m_beats.push_back(ustrm_data);
                    if (idx == BEATS - 1) begin
                        for (int b = 0; b < BEATS; b++) all[64*b +: 64] = m_beats[b];
                        if (ref_fold(all) != ustrm_crc) begin
                            m_err = 1;
                            m_crc++;
                        end
                        m_pend.data = all;
                        m_pend.prot = m_prot;
                        m_pend.err  = m_err;
                        m_pend_v    = 1;
                        m_beats.delete();
                    end
                end
            end
        end
    end

    function automatic logic [255:0] sat(input int v);
        return 256'((v > 255) ? 255 : v);
    endfunction

    // Per-cycle compare of every output against the model.
    always @(negedge clk_wr) begin
        if (live && !rst_wr) begin
            chk("flit_valid", 256'(flit_valid), 256'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) begin
                chk("flit_data", flit_data, m_fifo[0].data);
                chk("flit_protid", 256'(flit_protid), 256'(m_fifo[0].prot));
                chk("flit_crc_err", 256'(flit_crc_err), 256'(m_fifo[0].err));
            end
            chk("lp_state", 256'(lp_state), 256'(m_lp));
            chk("abort_cnt", 256'(abort_cnt), sat(m_abort));
            chk("frame_err_cnt", 256'(frame_err_cnt), sat(m_frame));
            chk("crc_err_cnt", 256'(crc_err_cnt), sat(m_crc));
            chk("ovfl_cnt", 256'(ovfl_cnt), sat(m_ovfl));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ustrm_valid = 0; ustrm_dvalid = 0; ustrm_crc_valid = 0;
        end
    endtask

    // Sends the first n beats of a flit with data base+b; protid p0 on beat 0,
    // pl afterwards; CRC XORed with cx; crc_valid also forced on beat index bad.
    task automatic send_flit(input logic [63:0] base, input logic [1:0] p0, input logic [1:0] pl,
                             input logic [3:0] cx, input int n, input int bad);
        logic [255:0] all;
        logic [3:0]   c;
        for (int b = 0; b < BEATS; b++) all[64*b +: 64] = base + 64'(b);
        c = ref_fold(all) ^ cx;
        for (int b = 0; b < n; b++) begin
            tick();
            ustrm_valid = 1; ustrm_dvalid = 1;
            ustrm_data = base + 64'(b);
            ustrm_protid = (b == 0) ? p0 : pl;
            ustrm_crc_valid = (b == BEATS - 1) || (b == bad);
            ustrm_crc = c;
        end
    endtask

    task automatic dump_head(input string tag);
        $display("%s: valid=%0b protid=%0d err=%0b lane0=%0h cnt a/f/c/o=%0d/%0d/%0d/%0d",
                 tag, flit_valid, flit_protid, flit_crc_err, flit_data[63:0],
                 abort_cnt, frame_err_cnt, crc_err_cnt, ovfl_cnt);
    endtask

    initial begin
        logic [255:0] exp1;
        logic [63:0]  lane0;
        exp1 = {64'd4, 64'd3, 64'd2, 64'd1};
        rst_wr = 1; rx_online = 1; ustrm_state = 4'h1; ustrm_protid = 0; ustrm_data = 0;
        ustrm_dvalid = 0; ustrm_crc = 0; ustrm_crc_valid = 0; ustrm_valid = 0; flit_ready = 1;
        repeat (3) tick();
        @(negedge clk_wr);
        chk("rst_valid", 256'(flit_valid), 256'(0));
        chk("rst_data", flit_data, 256'(0));
        chk("rst_lp_state", 256'(lp_state), 256'(0));
        chk("rst_cnts", 256'({abort_cnt, frame_err_cnt, crc_err_cnt, ovfl_cnt}), 256'(0));
        tick(); rst_wr = 0;

        // Clean flit 1..4, protid 2: fold = 1^2^3^4 = 4'h4.
        send_flit(64'h1, 2'd2, 2'd2, 4'h0, 4, -1);
        idle(1);
        @(negedge clk_wr); chk("t1_lat_not_yet", 256'(flit_valid), 256'(0));
        @(negedge clk_wr); chk("t1_valid", 256'(flit_valid), 256'(1));
        chk("t1_data", flit_data, exp1);
        chk("t1_err", 256'(flit_crc_err), 256'(0));
        chk("t1_protid", 256'(flit_protid), 256'(2));
        dump_head("clean flit");
        idle(3);

        // Bad CRC.
        send_flit(64'h1, 2'd2, 2'd2, 4'h1, 4, -1);
        idle(1);
        @(negedge clk_wr); @(negedge clk_wr);
        chk("t2_err", 256'(flit_crc_err), 256'(1));
        chk("t2_crc_cnt", 256'(crc_err_cnt), 256'(1));
        dump_head("crc error flit");
        idle(3);

        // Protid changes on later beats: flagged, not a CRC count.
        send_flit(64'h20, 2'd1, 2'd3, 4'h0, 4, -1);
        idle(1);
        @(negedge clk_wr); @(negedge clk_wr);
        chk("t2b_err", 256'(flit_crc_err), 256'(1));
        chk("t2b_crc_cnt", 256'(crc_err_cnt), 256'(1));
        dump_head("protid mismatch flit");
        idle(3);

        // crc_valid on beat 2 of 4, then a clean flit.
        send_flit(64'h30, 2'd1, 2'd1, 4'h0, 2, 1);
        idle(2);
        @(negedge clk_wr);
        chk("t3_frame_cnt", 256'(frame_err_cnt), 256'(1));
        chk("t3_no_flit", 256'(flit_valid), 256'(0));
        send_flit(64'h40, 2'd1, 2'd1, 4'h0, 4, -1);
        idle(1);
        @(negedge clk_wr); @(negedge clk_wr);
        lane0 = flit_data[63:0];
        chk("t3_next_lane0", 256'(lane0), 256'(64'h40));
        dump_head("after framing error");
        idle(3);

        // Abort: state drops after beat 1 while a beat strobe is present.
        send_flit(64'h50, 2'd0, 2'd0, 4'h0, 1, -1);
        tick(); ustrm_state = 4'h0;
        tick(); ustrm_valid = 0; ustrm_dvalid = 0; ustrm_state = 4'h1;
        @(negedge clk_wr);
        chk("t4_abort_cnt", 256'(abort_cnt), 256'(1));
        chk("t4_lp_state", 256'(lp_state), 256'(0));
        chk("t4_no_flit", 256'(flit_valid), 256'(0));
        send_flit(64'h60, 2'd3, 2'd3, 4'h0, 4, -1);
        idle(1);
        @(negedge clk_wr); @(negedge clk_wr);
        chk("t4_next_valid", 256'(flit_valid), 256'(1));
        dump_head("after abort");
        idle(3);

        // Six back-to-back flits with the consumer stalled.
        flit_ready = 0;
        for (int f = 0; f < 6; f++)
            send_flit(64'h100 + 64'(16 * f), 2'(f), 2'(f), 4'h0, 4, -1);
        idle(3);
        @(negedge clk_wr);
        chk("t5_ovfl", 256'(ovfl_cnt), 256'(2));
        lane0 = flit_data[63:0];
        chk("t5_head_lane0", 256'(lane0), 256'(64'h100));
        dump_head("stalled fifo");
        tick(); flit_ready = 1;
        idle(8);

        // Reset mid-flit with one flit held in the FIFO.
        flit_ready = 0;
        send_flit(64'h200, 2'd1, 2'd1, 4'h0, 4, -1);
        idle(3);
        send_flit(64'h300, 2'd1, 2'd1, 4'h0, 2, -1);
        tick(); rst_wr = 1; ustrm_valid = 0; ustrm_dvalid = 0;
        tick();
        tick(); rst_wr = 0;
        @(negedge clk_wr);
        chk("t6_valid", 256'(flit_valid), 256'(0));
        chk("t6_data", flit_data, 256'(0));
        chk("t6_prot_err", 256'({flit_protid, flit_crc_err}), 256'(0));
        chk("t6_lp_state", 256'(lp_state), 256'(0));
        chk("t6_cnts", 256'({abort_cnt, frame_err_cnt, crc_err_cnt, ovfl_cnt}), 256'(0));
        flit_ready = 1;
        send_flit(64'h400, 2'd2, 2'd2, 4'h0, 4, -1);
        idle(1);
        @(negedge clk_wr); @(negedge clk_wr);
        lane0 = flit_data[63:0];
        chk("t6_next_lane0", 256'(lane0), 256'(64'h400));
        dump_head("after reset");
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
